// File: rtl/hit_readout_clr_pkg.sv
// Shared definitions for the hit readout / clear block.
// Contents:
//   TRIG_WIDTH   - number of hit channels of the input register
//   TRIG_CH_BITS - width of a channel number
//   state_t      - readout FSM states
package trig_pkg;

  localparam int TRIG_WIDTH   = 48;
  localparam int TRIG_CH_BITS = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    CLR    = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/hit_readout_clr_if.sv
// Channel-report handshake between the readout block and its consumer.
// Signals:
//   hit_valid - a channel number is presented (driven by master)
//   hit_ch    - channel number being reported (driven by master)
//   hit_ready - consumer accepts hit_ch (driven by slave)
interface hit_readout_clr_if
  import trig_pkg::*;
#(
  parameter int CH_BITS = TRIG_CH_BITS
);

  logic               hit_valid;
  logic [CH_BITS-1:0] hit_ch;
  logic               hit_ready;

  modport master (output hit_valid, output hit_ch, input hit_ready);
  modport slave  (input hit_valid, input hit_ch, output hit_ready);

endinterface

// File: rtl/hit_readout_clr_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vec - input bit vector (WIDTH)
//   idx - index of the lowest set bit of vec, 0 when vec is empty (CH_BITS)
//   any - vec has at least one bit set
module prio_enc_lsb
  import trig_pkg::*;
#(
  parameter int WIDTH   = TRIG_WIDTH,
  parameter int CH_BITS = TRIG_CH_BITS
) (
  input  logic [WIDTH-1:0]   vec,
  output logic [CH_BITS-1:0] idx,
  output logic               any
);

  // Walk from the top down so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = {CH_BITS{1'b0}};
    any = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CH_BITS'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/hit_readout_clr.sv
// Consumer side of the edge-latching hit register: synchronises the latched
// hit bits, reports each set channel (lowest first) over a valid/ready
// handshake, pulses that channel's clear and confirms the bit dropped.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   hit_q       - latched hit bits, asynchronous to clk
//   enable      - allows new scans to start
//   bus         - hit_valid / hit_ch / hit_ready report handshake (master)
//   clr         - one-hot per-channel clear back to the hit register
//   busy        - FSM is not idle
//   stuck       - sticky: a channel failed to clear in time
//   stuck_ch    - channel of the most recent stuck event
module hit_readout_clr
  import trig_pkg::*;
#(
  parameter int WIDTH      = TRIG_WIDTH,
  parameter int CH_BITS    = TRIG_CH_BITS,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     hit_q,
  input  logic                 enable,
  hit_readout_clr_if.master    bus,
  output logic [WIDTH-1:0]     clr,
  output logic                 busy,
  output logic                 stuck,
  output logic [CH_BITS-1:0]   stuck_ch
);

  localparam int CNT_BITS = 8;

  logic [WIDTH-1:0]    sync1_r;
  logic [WIDTH-1:0]    hs_r;
  logic [WIDTH-1:0]    snap_r, snap_n_s;
  logic [WIDTH-1:0]    clr_r, clr_n_s;
  state_t              state_r, state_n_s;
  logic                hit_valid_r, hit_valid_n_s;
  logic [CH_BITS-1:0]  hit_ch_r, hit_ch_n_s;
  logic [CNT_BITS-1:0] cnt_r, cnt_n_s;
  logic                busy_r;
  logic                stuck_r, stuck_n_s;
  logic [CH_BITS-1:0]  stuck_ch_r, stuck_ch_n_s;
  logic [CH_BITS-1:0]  low_ch_s;
  logic                low_any_s;
  logic                hs_ch_s;

  function automatic logic [WIDTH-1:0] onehot_f(input logic [CH_BITS-1:0] ch);
    logic [WIDTH-1:0] oh;
    for (int i = 0; i < WIDTH; i++) begin
      oh[i] = (CH_BITS'(i) == ch);
    end
    return oh;
  endfunction

  prio_enc_lsb #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) u_prio (
    .vec (snap_r),
    .idx (low_ch_s),
    .any (low_any_s)
  );

  // hit_ch holds the channel being serviced through CLR and SETTLE as well.
  assign hs_ch_s = |(hs_r & onehot_f(hit_ch_r));

  // Two-flop synchroniser; nothing else looks at raw hit_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {WIDTH{1'b0}};
      hs_r    <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= hit_q;
      hs_r    <= sync1_r;
    end
  end

  // Next-state and next-output logic of the readout FSM.
  always_comb begin
    state_n_s     = state_r;
    snap_n_s      = snap_r;
    hit_valid_n_s = hit_valid_r;
    hit_ch_n_s    = hit_ch_r;
    clr_n_s       = clr_r;
    cnt_n_s       = cnt_r;
    stuck_n_s     = stuck_r;
    stuck_ch_n_s  = stuck_ch_r;
    case (state_r)
      IDLE: begin
        if (enable && (|hs_r)) begin
          snap_n_s  = hs_r;
          state_n_s = SCAN;
        end else begin
          state_n_s = IDLE;
        end
      end
      SCAN: begin
        if (hit_valid_r) begin
          // hit_ch is frozen while presented; only the handshake moves on.
          if (bus.hit_ready) begin
            snap_n_s      = snap_r & ~onehot_f(hit_ch_r);
            hit_valid_n_s = 1'b0;
            clr_n_s       = onehot_f(hit_ch_r);
            cnt_n_s       = {CNT_BITS{1'b0}};
            state_n_s     = CLR;
          end else begin
            hit_valid_n_s = 1'b1;
          end
        end else if (low_any_s) begin
          hit_valid_n_s = 1'b1;
          hit_ch_n_s    = low_ch_s;
        end else begin
          state_n_s = IDLE;
        end
      end
      CLR: begin
        if (cnt_r == CNT_BITS'(CLR_CYCLES - 1)) begin
          clr_n_s   = {WIDTH{1'b0}};
          cnt_n_s   = {CNT_BITS{1'b0}};
          state_n_s = SETTLE;
        end else begin
          cnt_n_s = cnt_r + CNT_BITS'(1);
        end
      end
      SETTLE: begin
        // A bit still set after SETTLE_MAX looks is flagged and skipped;
        // the next scan picks it up again from hs.
        if (!hs_ch_s) begin
          state_n_s = SCAN;
        end else if (cnt_r == CNT_BITS'(SETTLE_MAX - 1)) begin
          stuck_n_s    = 1'b1;
          stuck_ch_n_s = hit_ch_r;
          state_n_s    = SCAN;
        end else begin
          cnt_n_s = cnt_r + CNT_BITS'(1);
        end
      end
      default: begin
        state_n_s     = IDLE;
        hit_valid_n_s = 1'b0;
        clr_n_s       = {WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state and registered outputs; reset truncates any clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      snap_r      <= {WIDTH{1'b0}};
      hit_valid_r <= 1'b0;
      hit_ch_r    <= {CH_BITS{1'b0}};
      clr_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_BITS{1'b0}};
      busy_r      <= 1'b0;
      stuck_r     <= 1'b0;
      stuck_ch_r  <= {CH_BITS{1'b0}};
    end else begin
      state_r     <= state_n_s;
      snap_r      <= snap_n_s;
      hit_valid_r <= hit_valid_n_s;
      hit_ch_r    <= hit_ch_n_s;
      clr_r       <= clr_n_s;
      cnt_r       <= cnt_n_s;
      busy_r      <= (state_n_s != IDLE);
      stuck_r     <= stuck_n_s;
      stuck_ch_r  <= stuck_ch_n_s;
    end
  end

  assign bus.hit_valid = hit_valid_r;
  assign bus.hit_ch    = hit_ch_r;
  assign clr           = clr_r;
  assign busy          = busy_r;
  assign stuck         = stuck_r;
  assign stuck_ch      = stuck_ch_r;

endmodule

// File: doc/hit_readout_clr.md
Name: hit_readout_clr

Overview:
- Consumer side of the 48-channel edge-latching input register.
- Synchronises the register's latched hit bits into the `clk` domain and reports each set channel as a channel number over a valid/ready handshake, lowest channel first.
- After each accepted report, issues a per-channel clear pulse back to the register's reset inputs, then confirms that the bit has dropped before reporting more.

Parameters:
- WIDTH, 48, number of hit channels.
- CH_BITS, 6, width of the channel number; must satisfy 2**CH_BITS >= WIDTH.
- CLR_CYCLES, 2, number of `clk` cycles each clear pulse is held high; must be >= 1.
- SETTLE_MAX, 4, cycles to wait for the synchronised bit to read 0 after the clear pulse ends; must be >= 3.

Ports:
- clk  in  1  single block clock (rising edge).
- rst_n  in  1  asynchronous, active-low reset.
- hit_q  in  WIDTH  latched hit bits from the input register; asynchronous to `clk`.
- enable  in  1  allows new scans to start.
- hit_valid  out  1  a channel number is presented.
- hit_ch  out  CH_BITS  channel number being reported.
- hit_ready  in  1  downstream accepts `hit_ch`.
- clr  out  WIDTH  per-channel clear to the input register reset inputs; at most one bit is high at a time.
- busy  out  1  FSM is not in IDLE.
- stuck  out  1  sticky flag: a channel failed to clear within SETTLE_MAX.
- stuck_ch  out  CH_BITS  channel number of the most recent stuck event.

Behaviour:
- Reset (`rst_n` = 0, async):
  - `hit_valid`, `hit_ch`, `clr`, `busy`, `stuck` and `stuck_ch` all go to 0 immediately.
  - The synchroniser, the snapshot and the FSM go to IDLE / all zeros.
  - A clear pulse in progress is truncated. The input register keeps its bit, and the bit is re-reported after reset.
- Synchroniser:
  - Two flops per bit, giving `hs`, a 2-cycle latency from `hit_q`.
  - No other logic reads raw `hit_q`.
- State IDLE:
  - If `enable` = 1 and `|hs` = 1: load `snap <= hs` and go to SCAN.
  - `busy` goes high on the cycle after that transition.
- State SCAN:
  - If `snap` = 0: go to IDLE.
  - Otherwise: `hit_ch` = index of the lowest set bit of `snap`, with `hit_valid` = 1 registered.
  - `hit_valid` and `hit_ch` stay stable until the handshake; `hit_ch` must not change while `hit_valid` = 1.
  - Handshake on a cycle with `hit_valid` & `hit_ready`:
    - clear `snap[hit_ch]`;
    - deassert `hit_valid` on the next cycle;
    - go to CLR.
- State CLR:
  - `clr[ch]` = 1 for exactly CLR_CYCLES cycles (counter), then 0, then go to SETTLE.
  - The input register narrows this pulse to half a clock internally. A pulse longer than one cycle is harmless because reset dominates.
- State SETTLE:
  - Wait until `hs[ch]` = 0, counting at most SETTLE_MAX cycles.
  - If `hs[ch]` reads 0: go to SCAN.
  - On timeout: set `stuck` = 1 and `stuck_ch` = ch, then go to SCAN. The channel is not retried in this scan.
- Rescan:
  - When SCAN finds `snap` empty it returns to IDLE.
  - IDLE re-samples `hs`, so hits that arrived during the scan are picked up on the next pass.
- Hits during a scan:
  - Channels outside `snap` are not reported until the next scan.
  - A new edge on a channel that has already been cleared, landing during SETTLE, shows up as `hs[ch]` = 1 at timeout. This is indistinguishable from stuck and is flagged stuck; the hit is reported next scan.
- `enable` deasserted mid-scan: the current scan completes; the next scan is not started.
- `stuck` is cleared only by reset.
- Per-hit minimum occupancy: 1 (handshake) + CLR_CYCLES + 3 cycles.

Decomposition:
- Shared package `trig_pkg`:
  - the FSM state enum {IDLE, SCAN, CLR, SETTLE};
  - constants `TRIG_WIDTH` = 48 and `TRIG_CH_BITS` = 6.
- One natural sub-module: `prio_enc_lsb` (WIDTH → CH_BITS plus `any` output), purely combinational, used in SCAN.
- The two-flop synchroniser stays inline.

Test Plan:
- Single hit:
  - Stimulus: assert `hit_q[5]` after reset; `hit_ready` = 1.
  - Response: `hit_valid` with `hit_ch` = 5, then `clr[5]` high for 2 cycles. The model drops `hit_q[5]` on `clr`; `busy` returns to 0; no other `clr` bit ever high.
- Multi-hit ordering:
  - Stimulus: `hit_q` bits {47, 0, 17} set simultaneously.
  - Response: reports in order 0, 17, 47, each followed by its own `clr` pulse; exactly 3 handshakes.
- Backpressure:
  - Stimulus: `hit_q[3]` set, `hit_ready` held 0 for 10 cycles.
  - Response: `hit_valid` = 1 and `hit_ch` = 3 stable for all 10 cycles; `clr` = 0 until the handshake.
- Stuck channel:
  - Stimulus: the model ignores `clr[9]` (bit stays 1).
  - Response: after CLR + 4 SETTLE cycles, `stuck` = 1 and `stuck_ch` = 9. Channel 9 is re-reported on the next scan.
- Reset mid-clear:
  - Stimulus: drop `rst_n` while `clr[12]` = 1.
  - Response: `clr` = 0 asynchronously and all outputs are 0. After release, channel 12 is reported again.
- Enable gating:
  - Stimulus: `enable` = 0 with `hit_q[1]` set.
  - Response: `busy` = 0 and no `hit_valid`. After `enable` = 1, channel 1 is reported within 4 cycles.
